rf_wr_ctrl: RTL and testbench
=============================

Name: rf_wr_ctrl

Overview:
- Controller for the 32x32 RISC-V register file's single write port (WE/A3/WD3).
- After reset it runs an init sweep that writes INIT_VAL into x1..x31.
- After the sweep it round-robin arbitrates two write-back requesters onto the port: req0 = ALU write-back, req1 = LSU load write-back.
- Sits between the execute/LSU stages and the register file; read ports are untouched.

Parameters:
- INIT_EN, 1, 1 = run the init sweep after reset; 0 = go straight to RUN.
- INIT_VAL, 32'h0000_0000, value written to x1..x31 during the sweep.
- CNT_W, 16, width of the saturating conflict counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  ALU write request.
- req0_addr  in  5  ALU destination register.
- req0_data  in  32  ALU write data.
- req0_ready  out  1  ALU request accepted this cycle.
- req1_valid  in  1  LSU write request.
- req1_addr  in  5  LSU destination register.
- req1_data  in  32  LSU write data.
- req1_ready  out  1  LSU request accepted this cycle.
- rf_we  out  1  to register file WE.
- rf_a3  out  5  to register file A3.
- rf_wd3  out  32  to register file WD3.
- init_done  out  1  high once in RUN.
- conflict_cnt  out  CNT_W  count of cycles with both requests valid (saturating).

Behaviour:
- Reset (async assert, sync release):
  - state = INIT if INIT_EN, else RUN; sweep counter = 1; last_grant = 1, so req0 wins the first tie.
  - rf_we = 0, rf_a3 = 0, rf_wd3 = 0, init_done = INIT_EN ? 0 : 1, conflict_cnt = 0, both readys = 0.
- States: INIT -> RUN. There is no return to INIT except via reset.
- INIT:
  - Each cycle register rf_we = 1, rf_a3 = cnt, rf_wd3 = INIT_VAL; cnt increments 1..31.
  - After the cycle that issues cnt = 31, go to RUN; init_done = 1 from the next cycle.
  - The sweep occupies 31 cycles; x0 is never written.
  - Both readys are held 0; requests wait.
- RUN arbitration (combinational in the cycle):
  - Only one valid: grant it.
  - Both valid: grant the requester not in last_grant; conflict_cnt += 1, saturating at all-ones.
  - reqN_ready = RUN && granted N. A handshake is valid && ready; last_grant updates to N on handshake.
  - Readys depend on the valids. Requesters must not make valid depend on ready.
- Write-out latency:
  - An accepted request appears on rf_we/rf_a3/rf_wd3 on the next cycle (registered outputs, 1-cycle latency).
  - With no handshake, rf_we = 0 the next cycle; rf_a3/rf_wd3 hold their previous values.
- x0 writes: the request is accepted (ready = 1, counts for round-robin), but rf_we is forced to 0 and rf_a3 = 0.
- Same destination in both requests, same cycle: only the granted one is written; the other is written at its later grant. Last writer wins, in grant order.
- Requester rules: addr/data must be stable while valid && !ready, and valid must not drop before the handshake. Violations are out of scope.
- Throughput: 1 write per cycle in RUN; a requester facing continuous contention gets every other cycle.
- Reset mid-sweep or mid-RUN: outputs clear immediately (rf_we = 0 asynchronously). A pending, unaccepted request is not retained; the requester re-presents it after reset.

Decomposition:
- Shared package (riscv_pkg):
  - RF_ADDR_W = 5, XLEN = 32, RF_DEPTH = 32, REG_ZERO = 5'd0.
  - State encoding ST_INIT/ST_RUN as localparams.
- One sub-module: rr_arb2 (2-way round-robin arbiter: valid[1:0], last_grant -> grant[1:0]). It is reused later for the register-file read-port sharing.
- Init counter, output registers and conflict counter live in rf_wr_ctrl.

Test Plan:
- Sweep:
  - Stimulus: release rst_n with INIT_EN = 1, INIT_VAL = 32'hDEAD_BEEF.
  - Required: rf_we = 1 with rf_a3 = 1..31 on consecutive cycles, rf_wd3 = DEADBEEF; init_done rises after the 31st write; no ready during the sweep.
- Single requester:
  - Stimulus: in RUN, req0 valid, addr = 5, data = 32'h1234 for one cycle.
  - Required: req0_ready = 1 the same cycle; next cycle rf_we = 1, rf_a3 = 5, rf_wd3 = 32'h1234; the following cycle rf_we = 0.
- Contention:
  - Stimulus: both valid for 4 cycles (req0 addr = 3, req1 addr = 3, different data).
  - Required: grants alternate req0, req1, req0, req1; conflict_cnt = 4; register 3 ends with the last granted data.
- x0 write:
  - Stimulus: req1 valid, addr = 0, data = 32'hFFFF_FFFF.
  - Required: req1_ready = 1; next cycle rf_we = 0.
- Reset mid-operation:
  - Stimulus: assert rst_n low at sweep cnt = 10, asynchronously between edges.
  - Required: rf_we drops to 0 before the next clock edge; after release the sweep restarts at rf_a3 = 1.
- Saturation:
  - Stimulus: CNT_W = 3, 10 contention cycles.
  - Required: conflict_cnt stops at 7.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared register-file constants and the write-controller state encoding.
package riscv_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int XLEN      = 32;
  localparam int RF_DEPTH  = 32;

  localparam logic [RF_ADDR_W-1:0] REG_ZERO   = 5'd0;
  localparam logic [RF_ADDR_W-1:0] SWEEP_LAST = 5'(RF_DEPTH - 1);

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  typedef struct packed {
    logic                 we;
    logic [RF_ADDR_W-1:0] a3;
    logic [XLEN-1:0]      wd3;
  } rf_wr_t;

  function automatic logic is_reg_zero(input logic [RF_ADDR_W-1:0] addr);
    return (addr == REG_ZERO);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; a tie goes to the requester not granted last.
module rr_arb2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic [1:0] o_grant
);

  // Grant decode: single requester wins outright, a tie alternates.
  always_comb begin
    o_grant = 2'b00;
    case (i_valid)
      2'b01:   o_grant = 2'b01;
      2'b10:   o_grant = 2'b10;
      2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/rf_wr_ctrl.sv
// Register-file write-port controller: post-reset init sweep of x1..x31, then
// round-robin sharing of the port between ALU and LSU write-back.
module rf_wr_ctrl
  import riscv_pkg::*;
#(
  parameter logic            INIT_EN  = 1'b1,
  parameter logic [XLEN-1:0] INIT_VAL = 32'h0000_0000,
  parameter int              CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  input  logic [RF_ADDR_W-1:0] req0_addr,
  input  logic [XLEN-1:0]      req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [RF_ADDR_W-1:0] req1_addr,
  input  logic [XLEN-1:0]      req1_data,
  output logic                 req1_ready,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_a3,
  output logic [XLEN-1:0]      rf_wd3,
  output logic                 init_done,
  output logic [CNT_W-1:0]     conflict_cnt
);

  logic                 r_state;
  logic                 w_state_nxt;
  logic [RF_ADDR_W-1:0] r_cnt;
  logic                 r_last_grant;
  logic [1:0]           w_grant;
  logic                 w_ready0;
  logic                 w_ready1;
  logic                 w_hs_any;
  logic [RF_ADDR_W-1:0] w_sel_addr;
  logic [XLEN-1:0]      w_sel_data;
  rf_wr_t               r_wr;
  rf_wr_t               w_wr_nxt;
  logic                 r_init_done;
  logic [CNT_W-1:0]     r_conf;

  rr_arb2 u_arb (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT_EN ? ST_INIT : ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: leave INIT once the last register has been issued.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == SWEEP_LAST) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_INIT;
        end
      end
      ST_RUN:  w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Output logic: readys are only offered in RUN.
  always_comb begin
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_ready0 = w_grant[0];
        w_ready1 = w_grant[1];
      end
      default: begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
      end
    endcase
  end

  assign req0_ready = w_ready0;
  assign req1_ready = w_ready1;
  assign w_hs_any   = (req0_valid & w_ready0) | (req1_valid & w_ready1);

  // Sweep counter; it parks at the last address once INIT is over.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 5'd1;
    end else if ((r_state == ST_INIT) && (r_cnt != SWEEP_LAST)) begin
      r_cnt <= r_cnt + 5'd1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Round-robin history, moved only by an actual handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (req0_valid && w_ready0) begin
      r_last_grant <= 1'b0;
    end else if (req1_valid && w_ready1) begin
      r_last_grant <= 1'b1;
    end else begin
      r_last_grant <= r_last_grant;
    end
  end

  // Next write-port value: sweep, accepted request, or idle with held a3/wd3.
  always_comb begin
    w_sel_addr = req0_addr;
    w_sel_data = req0_data;
    if (w_ready1) begin
      w_sel_addr = req1_addr;
      w_sel_data = req1_data;
    end else begin
      w_sel_addr = req0_addr;
      w_sel_data = req0_data;
    end

    w_wr_nxt = r_wr;
    if (r_state == ST_INIT) begin
      w_wr_nxt.we  = 1'b1;
      w_wr_nxt.a3  = r_cnt;
      w_wr_nxt.wd3 = INIT_VAL;
    end else if (w_hs_any) begin
      if (is_reg_zero(w_sel_addr)) begin
        // x0 is architecturally zero: accept the request but suppress the write.
        w_wr_nxt.we = 1'b0;
        w_wr_nxt.a3 = REG_ZERO;
      end else begin
        w_wr_nxt.we  = 1'b1;
        w_wr_nxt.a3  = w_sel_addr;
        w_wr_nxt.wd3 = w_sel_data;
      end
    end else begin
      w_wr_nxt.we = 1'b0;
    end
  end

  // Registered write port and init flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr        <= '0;
      r_init_done <= INIT_EN ? 1'b0 : 1'b1;
    end else begin
      r_wr        <= w_wr_nxt;
      r_init_done <= (w_state_nxt == ST_RUN);
    end
  end

  // Saturating count of RUN cycles where both requesters contend.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conf <= '0;
    end else if ((r_state == ST_RUN) && req0_valid && req1_valid && (r_conf != '1)) begin
      r_conf <= r_conf + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_conf <= r_conf;
    end
  end

  assign rf_we        = r_wr.we;
  assign rf_a3        = r_wr.a3;
  assign rf_wd3       = r_wr.wd3;
  assign init_done    = r_init_done;
  assign conflict_cnt = r_conf;

endmodule

// File: tb/tb_rf_wr_ctrl.sv
// Bench for rf_wr_ctrl: directed sweep/arbitration/reset cases plus random
// traffic, checked against a register-file-level reference model.
module tb_rf_wr_ctrl;

  localparam logic [31:0] IVAL = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready, rf_we, init_done;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd3;
  logic [15:0] conflict_cnt;
  logic        s_req0_ready, s_req1_ready, s_rf_we, s_init_done;
  logic [4:0]  s_rf_a3;
  logic [31:0] s_rf_wd3;
  logic [2:0]  s_conflict_cnt;

  rf_wr_ctrl #(.INIT_EN(1'b1), .INIT_VAL(IVAL), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd3(rf_wd3), .init_done(init_done), .conflict_cnt(conflict_cnt)
  );

  rf_wr_ctrl #(.INIT_EN(1'b1), .INIT_VAL(IVAL), .CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(s_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(s_req1_ready),
    .rf_we(s_rf_we), .rf_a3(s_rf_a3), .rf_wd3(s_rf_wd3), .init_done(s_init_done), .conflict_cnt(s_conflict_cnt)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  // Reference model: phase, next sweep address, who won last, contention total.
  bit          m_run;
  int          m_cnt;
  int          m_last;
  int          m_conf;
  logic        e_we;
  logic [4:0]  e_a3;
  logic [31:0] e_wd3;
  logic [31:0] ref_rf [32];
  logic [31:0] dut_rf [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_cnt = 1; m_last = 1; m_conf = 0;
    e_we = 1'b0; e_a3 = 5'd0; e_wd3 = 32'd0;
  endtask

  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bit g0, g1;
    logic [4:0]  a;
    logic [31:0] d;
    @(negedge clk);
    req0_valid = v0; req0_addr = a0; req0_data = d0;
    req1_valid = v1; req1_addr = a1; req1_data = d1;
    #1;
    g0 = 1'b0; g1 = 1'b0;
    if (m_run) begin
      if (v0 && v1) begin
        m_conf++;
        if (m_last == 1) g0 = 1'b1; else g1 = 1'b1;
      end else if (v0) g0 = 1'b1;
      else if (v1) g1 = 1'b1;
    end
    chk("req0_ready", {31'd0, req0_ready}, {31'd0, g0});
    chk("req1_ready", {31'd0, req1_ready}, {31'd0, g1});
    chk("sat_req0_ready", {31'd0, s_req0_ready}, {31'd0, g0});
    chk("sat_req1_ready", {31'd0, s_req1_ready}, {31'd0, g1});
    if (!m_run) begin
      e_we = 1'b1; e_a3 = 5'(m_cnt); e_wd3 = IVAL;
      ref_rf[m_cnt] = IVAL;
      if (m_cnt == 31) m_run = 1'b1; else m_cnt++;
    end else if (g0 || g1) begin
      a = g0 ? a0 : a1;
      d = g0 ? d0 : d1;
      m_last = g0 ? 0 : 1;
      if (a == 5'd0) begin
        e_we = 1'b0; e_a3 = 5'd0;
      end else begin
        e_we = 1'b1; e_a3 = a; e_wd3 = d;
        ref_rf[a] = d;
      end
    end else begin
      e_we = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
    chk("rf_a3", {27'd0, rf_a3}, {27'd0, e_a3});
    chk("rf_wd3", rf_wd3, e_wd3);
    chk("init_done", {31'd0, init_done}, {31'd0, m_run});
    chk("conflict_cnt", {16'd0, conflict_cnt}, (m_conf > 65535) ? 32'd65535 : 32'(m_conf));
    chk("sat_conflict_cnt", {29'd0, s_conflict_cnt}, (m_conf > 7) ? 32'd7 : 32'(m_conf));
    chk("sat_rf_we", {31'd0, s_rf_we}, {31'd0, e_we});
    chk("sat_rf_a3", {27'd0, s_rf_a3}, {27'd0, e_a3});
    if (rf_we) dut_rf[rf_a3] = rf_wd3;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we"}, {31'd0, rf_we}, 32'd0);
    chk({tag, "_a3"}, {27'd0, rf_a3}, 32'd0);
    chk({tag, "_wd3"}, rf_wd3, 32'd0);
    chk({tag, "_done"}, {31'd0, init_done}, 32'd0);
    chk({tag, "_conf"}, {16'd0, conflict_cnt}, 32'd0);
    chk({tag, "_ready"}, {30'd0, req1_ready, req0_ready}, 32'd0);
  endtask

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = 5'd0; req0_data = 32'd0;
    req1_valid = 1'b0; req1_addr = 5'd0; req1_data = 32'd0;
    for (int i = 0; i < 32; i++) begin ref_rf[i] = 32'd0; dut_rf[i] = 32'd0; end
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    #1 rst_n = 1'b1;

    // Partial sweep with random request noise, then async reset at cnt = 10.
    for (int i = 0; i < 10; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 1'($urandom_range(0, 1)), 5'($urandom), $urandom);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    model_reset();
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Full sweep from x1.
    for (int i = 0; i < 31; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 1'($urandom_range(0, 1)), 5'($urandom), $urandom);

    // Contention on x3: req0 first, then alternating.
    for (int i = 0; i < 4; i++)
      step(1'b1, 5'd3, 32'hA000_0000 + 32'(i), 1'b1, 5'd3, 32'hB000_0000 + 32'(i));
    chk("contention_cnt", {16'd0, conflict_cnt}, 32'd4);

    // Single requester then idle.
    step(1'b1, 5'd5, 32'h0000_1234, 1'b0, 5'd0, 32'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // x0 write from LSU is accepted but not written.
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Random traffic.
    for (int i = 0; i < 200; i++)
      step(1'($urandom_range(0, 1)), 5'($urandom), $urandom, 1'($urandom_range(0, 1)), 5'($urandom), $urandom);

    // Saturation of the narrow counter.
    for (int i = 0; i < 10; i++)
      step(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
    chk("saturated_cnt", {29'd0, s_conflict_cnt}, 32'd7);

    // Final register-file image written by the port versus the model.
    for (int i = 0; i < 32; i++)
      chk($sformatf("rf_x%0d", i), dut_rf[i], ref_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
